// File: rtl/mem_wb_pipe_reg.sv
// MEM/WB pipeline register: stall/flush control, qualified write enable,
// 3-way write-back data mux and a retired-instruction counter.
module mem_wb_pipe_reg #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int COUNT_WIDTH    = 32,
    parameter int SUPPRESS_R0    = 1
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      StallIn,
    input  logic                      FlushIn,
    input  logic                      ValidIn,
    input  logic                      RegWriteIn,
    input  logic [1:0]                MemToRegIn,
    input  logic [DATA_WIDTH-1:0]     ALUResultIn,
    input  logic [DATA_WIDTH-1:0]     MemDataIn,
    input  logic [DATA_WIDTH-1:0]     LinkAddrIn,
    input  logic [REG_ADDR_WIDTH-1:0] WriteRegIn,
    output logic                      ValidOut,
    output logic                      RegWriteOut,
    output logic [1:0]                MemToRegOut,
    output logic [DATA_WIDTH-1:0]     ALUResultOut,
    output logic [DATA_WIDTH-1:0]     MemDataOut,
    output logic [DATA_WIDTH-1:0]     LinkAddrOut,
    output logic [REG_ADDR_WIDTH-1:0] WriteRegOut,
    output logic [DATA_WIDTH-1:0]     WriteDataOut,
    output logic [COUNT_WIDTH-1:0]    RetiredCount
);

    localparam logic SUPPRESS = (SUPPRESS_R0 != 0);

    logic                      valid_q,    valid_d;
    logic                      regwrite_q, regwrite_d;
    logic [1:0]                memtoreg_q, memtoreg_d;
    logic [DATA_WIDTH-1:0]     alu_q,      alu_d;
    logic [DATA_WIDTH-1:0]     mem_q,      mem_d;
    logic [DATA_WIDTH-1:0]     link_q,     link_d;
    logic [REG_ADDR_WIDTH-1:0] wreg_q,     wreg_d;
    logic [COUNT_WIDTH-1:0]    count_q,    count_d;
    logic                      retire;
    logic                      r0_write;

    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        memtoreg_d = memtoreg_q;
        alu_d      = alu_q;
        mem_d      = mem_q;
        link_d     = link_q;
        wreg_d     = wreg_q;
        r0_write   = SUPPRESS && (WriteRegIn == '0);

        // A flush only clears control; data fields keep their old contents.
        if (FlushIn) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            memtoreg_d = 2'b00;
        end else if (!StallIn) begin
            valid_d    = ValidIn;
            regwrite_d = RegWriteIn & ValidIn & ~r0_write;
            memtoreg_d = MemToRegIn;
            alu_d      = ALUResultIn;
            mem_d      = MemDataIn;
            link_d     = LinkAddrIn;
            wreg_d     = WriteRegIn;
        end

        // The current occupant retires whenever it is allowed to leave WB,
        // even if the slot behind it is being flushed.
        retire  = valid_q & ~StallIn;
        count_d = count_q + {{(COUNT_WIDTH-1){1'b0}}, retire};
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 2'b00;
            alu_q      <= '0;
            mem_q      <= '0;
            link_q     <= '0;
            wreg_q     <= '0;
            count_q    <= '0;
        end else begin
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            memtoreg_q <= memtoreg_d;
            alu_q      <= alu_d;
            mem_q      <= mem_d;
            link_q     <= link_d;
            wreg_q     <= wreg_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        WriteDataOut = '0;
        case (memtoreg_q)
            2'b00:   WriteDataOut = alu_q;
            2'b01:   WriteDataOut = mem_q;
            2'b10:   WriteDataOut = link_q;
            default: WriteDataOut = '0;
        endcase
    end

    assign ValidOut     = valid_q;
    assign RegWriteOut  = regwrite_q;
    assign MemToRegOut  = memtoreg_q;
    assign ALUResultOut = alu_q;
    assign MemDataOut   = mem_q;
    assign LinkAddrOut  = link_q;
    assign WriteRegOut  = wreg_q;
    assign RetiredCount = count_q;

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Bench for mem_wb_pipe_reg: three parameterisations share one stimulus stream
// and are compared against a slot-level reference model.
module tb_mem_wb_pipe_reg;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        StallIn, FlushIn, ValidIn, RegWriteIn;
    logic [1:0]  MemToRegIn;
    logic [31:0] ALUResultIn, MemDataIn, LinkAddrIn;
    logic [4:0]  WriteRegIn;

    logic        ValidOut, RegWriteOut;
    logic [1:0]  MemToRegOut;
    logic [31:0] ALUResultOut, MemDataOut, LinkAddrOut, WriteDataOut, RetiredCount;
    logic [4:0]  WriteRegOut;

    logic        v0, rw0;
    logic [1:0]  src0;
    logic [31:0] alu0, mem0, link0, wd0, cnt0;
    logic [4:0]  wr0;

    logic        v4, rw4;
    logic [1:0]  src4;
    logic [31:0] alu4, mem4, link4, wd4;
    logic [4:0]  wr4;
    logic [3:0]  cnt4;

    int checks   = 0;
    int failures = 0;

    // Reference model: one WB slot plus retire tallies for each variant.
    bit          m_valid, m_rw_sup, m_rw_nosup;
    int unsigned m_src;
    logic [31:0] m_alu, m_mem, m_link;
    int unsigned m_wreg;
    int unsigned m_cnt32, m_cnt4;

    always #5 Clock = ~Clock;

    mem_wb_pipe_reg dut (
        .Clock(Clock), .Reset(Reset), .StallIn(StallIn), .FlushIn(FlushIn),
        .ValidIn(ValidIn), .RegWriteIn(RegWriteIn), .MemToRegIn(MemToRegIn),
        .ALUResultIn(ALUResultIn), .MemDataIn(MemDataIn), .LinkAddrIn(LinkAddrIn),
        .WriteRegIn(WriteRegIn), .ValidOut(ValidOut), .RegWriteOut(RegWriteOut),
        .MemToRegOut(MemToRegOut), .ALUResultOut(ALUResultOut), .MemDataOut(MemDataOut),
        .LinkAddrOut(LinkAddrOut), .WriteRegOut(WriteRegOut), .WriteDataOut(WriteDataOut),
        .RetiredCount(RetiredCount)
    );

    mem_wb_pipe_reg #(.SUPPRESS_R0(0)) dut_nosup (
        .Clock(Clock), .Reset(Reset), .StallIn(StallIn), .FlushIn(FlushIn),
        .ValidIn(ValidIn), .RegWriteIn(RegWriteIn), .MemToRegIn(MemToRegIn),
        .ALUResultIn(ALUResultIn), .MemDataIn(MemDataIn), .LinkAddrIn(LinkAddrIn),
        .WriteRegIn(WriteRegIn), .ValidOut(v0), .RegWriteOut(rw0),
        .MemToRegOut(src0), .ALUResultOut(alu0), .MemDataOut(mem0),
        .LinkAddrOut(link0), .WriteRegOut(wr0), .WriteDataOut(wd0),
        .RetiredCount(cnt0)
    );

    mem_wb_pipe_reg #(.COUNT_WIDTH(4)) dut_cw4 (
        .Clock(Clock), .Reset(Reset), .StallIn(StallIn), .FlushIn(FlushIn),
        .ValidIn(ValidIn), .RegWriteIn(RegWriteIn), .MemToRegIn(MemToRegIn),
        .ALUResultIn(ALUResultIn), .MemDataIn(MemDataIn), .LinkAddrIn(LinkAddrIn),
        .WriteRegIn(WriteRegIn), .ValidOut(v4), .RegWriteOut(rw4),
        .MemToRegOut(src4), .ALUResultOut(alu4), .MemDataOut(mem4),
        .LinkAddrOut(link4), .WriteRegOut(wr4), .WriteDataOut(wd4),
        .RetiredCount(cnt4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_rw_sup = 0; m_rw_nosup = 0; m_src = 0;
        m_alu = 0; m_mem = 0; m_link = 0; m_wreg = 0;
        m_cnt32 = 0; m_cnt4 = 0;
    endtask

    task automatic model_edge();
        if (Reset) begin
            model_reset();
            return;
        end
        if (m_valid && !StallIn) begin
            m_cnt32 = m_cnt32 + 1;
            m_cnt4  = (m_cnt4 + 1) % 16;
        end
        if (FlushIn) begin
            m_valid = 0; m_rw_sup = 0; m_rw_nosup = 0; m_src = 0;
        end else if (!StallIn) begin
            m_valid    = ValidIn;
            m_rw_nosup = RegWriteIn && ValidIn;
            m_rw_sup   = m_rw_nosup && (WriteRegIn != 0);
            m_src      = MemToRegIn;
            m_alu      = ALUResultIn;
            m_mem      = MemDataIn;
            m_link     = LinkAddrIn;
            m_wreg     = WriteRegIn;
        end
    endtask

    task automatic check_all(input string ph);
        logic [31:0] sel [4];
        sel = '{m_alu, m_mem, m_link, 32'h0};
        chk({ph, ".valid"},     ValidOut,     m_valid);
        chk({ph, ".regwrite"},  RegWriteOut,  m_rw_sup);
        chk({ph, ".memtoreg"},  MemToRegOut,  m_src);
        chk({ph, ".alu"},       ALUResultOut, m_alu);
        chk({ph, ".mem"},       MemDataOut,   m_mem);
        chk({ph, ".link"},      LinkAddrOut,  m_link);
        chk({ph, ".wreg"},      WriteRegOut,  m_wreg);
        chk({ph, ".wdata"},     WriteDataOut, sel[m_src]);
        chk({ph, ".count"},     RetiredCount, m_cnt32);
        chk({ph, ".nosup_rw"},  rw0,          m_rw_nosup);
        chk({ph, ".nosup_wd"},  wd0,          sel[m_src]);
        chk({ph, ".cw4_rw"},    rw4,          m_rw_sup);
        chk({ph, ".cw4_count"}, cnt4,         m_cnt4);
    endtask

    task automatic step(input string ph);
        @(posedge Clock);
        model_edge();
        #1;
        check_all(ph);
    endtask

    task automatic rand_data();
        ValidIn     = 1'($urandom);
        RegWriteIn  = 1'($urandom);
        MemToRegIn  = 2'($urandom);
        ALUResultIn = $urandom;
        MemDataIn   = $urandom;
        LinkAddrIn  = $urandom;
        WriteRegIn  = 5'($urandom);
    endtask

    initial begin
        // reset applied between edges with every input nonzero
        StallIn = 1; FlushIn = 1; ValidIn = 1; RegWriteIn = 1; MemToRegIn = 2'b10;
        ALUResultIn = 32'hFFFF_FFFF; MemDataIn = 32'h1234_5678;
        LinkAddrIn = 32'h0040_0008; WriteRegIn = 5'd31;
        Reset = 0;
        #1 Reset = 1;
        #1;
        model_reset();
        check_all("async_reset");
        step("reset_held");
        Reset = 0;
        StallIn = 0; FlushIn = 0; ValidIn = 0; RegWriteIn = 0;
        step("post_release");

        // single load through memory source
        ValidIn = 1; RegWriteIn = 1; MemToRegIn = 2'b01;
        MemDataIn = 32'hDEAD_BEEF; WriteRegIn = 5'd8;
        step("load_mem");
        ValidIn = 0; RegWriteIn = 0;
        step("retire_one");
        chk("retire_one.abs", RetiredCount, 32'd1);

        // destination r0
        ValidIn = 1; RegWriteIn = 1; WriteRegIn = 5'd0; MemToRegIn = 2'b00;
        step("r0_write");
        chk("r0_write.sup_abs", RegWriteOut, 1'b0);
        chk("r0_write.nosup_abs", rw0, 1'b1);

        // stall with changing inputs, then stall+flush together
        ValidIn = 1; RegWriteIn = 1; WriteRegIn = 5'd3;
        step("pre_stall");
        StallIn = 1;
        for (int i = 0; i < 3; i++) begin
            rand_data();
            step("stall");
        end
        FlushIn = 1;
        rand_data();
        step("stall_flush");
        StallIn = 0; FlushIn = 0;

        // write-back source sweep
        ValidIn = 1; RegWriteIn = 1; WriteRegIn = 5'd4;
        ALUResultIn = 32'h10; LinkAddrIn = 32'h0040_0008; MemDataIn = 32'h5555_AAAA;
        MemToRegIn = 2'b00;
        step("src_alu");
        chk("src_alu.abs", WriteDataOut, 32'h10);
        MemToRegIn = 2'b10;
        step("src_link");
        chk("src_link.abs", WriteDataOut, 32'h0040_0008);
        MemToRegIn = 2'b11;
        step("src_rsvd");
        chk("src_rsvd.abs", WriteDataOut, 32'h0);

        // counter wrap on the 4-bit variant
        Reset = 1;
        #1;
        model_reset();
        check_all("wrap_reset");
        @(negedge Clock);
        Reset = 0;
        ValidIn = 1;
        for (int i = 0; i < 17; i++) begin
            rand_data();
            ValidIn = 1;
            step("wrap_load");
        end
        ValidIn = 0;
        step("wrap_end");
        chk("wrap_end.cw4_abs", cnt4, 4'd1);
        chk("wrap_end.cw32_abs", RetiredCount, 32'd17);

        // reset during a stall wins immediately
        ValidIn = 1; RegWriteIn = 1; WriteRegIn = 5'd9;
        step("pre_mid_reset");
        StallIn = 1; FlushIn = 1;
        step("mid_flush_stall");
        #2 Reset = 1;
        #1;
        model_reset();
        check_all("mid_reset");
        @(negedge Clock);
        Reset = 0;
        StallIn = 0; FlushIn = 0;
        step("first_after_reset");

        // random traffic
        for (int i = 0; i < 300; i++) begin
            rand_data();
            StallIn = ($urandom_range(0, 3) == 0);
            FlushIn = ($urandom_range(0, 5) == 0);
            step("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
